// File: rtl/serial_shift_alu.sv
// Execution-stage ALU. Single-cycle arithmetic, logic and compare ops; shifts
// are done serially, one bit per cycle, with busy held while a shift runs.
module serial_shift_alu #(
   parameter int XLEN = 32,
   parameter int SHW  = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            valid_in,
   input  logic [3:0]      alu_control,
   input  logic            is_shamt,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   input  logic [XLEN-1:0] imm,
   output logic            busy,
   output logic            valid_out,
   output logic [XLEN-1:0] result,
   output logic            cmp
);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t          state, state_next;
   logic [XLEN-1:0] op_b;
   logic [XLEN-1:0] alu_result;
   logic            alu_cmp;
   logic [SHW-1:0]  shamt;
   logic            is_shift;
   logic            accept;
   logic            start_shift;
   logic            last_step;
   logic [XLEN-1:0] shreg, shreg_step;
   logic [SHW-1:0]  cnt;
   logic            sh_left, sh_arith;

   assign op_b        = is_shamt ? imm : rs2;
   assign shamt       = op_b[SHW-1:0];
   assign is_shift    = alu_control inside {4'h2, 4'h6, 4'h7};
   assign accept      = valid_in && (state == IDLE);
   assign start_shift = accept && is_shift && (shamt != '0);
   assign last_step   = (state == SHIFT) && (cnt == SHW'(1));
   assign busy        = (state == SHIFT);

   // sra keeps the sign bit in shreg[XLEN-1] on every step, so it is the fill.
   assign shreg_step = sh_left ? {shreg[XLEN-2:0], 1'b0}
                               : {sh_arith & shreg[XLEN-1], shreg[XLEN-1:1]};

   // NOTE: every output of a combinational block gets a default first so no path infers a latch.
   always_comb begin
      alu_result = '0;
      alu_cmp    = 1'b0;
      case (alu_control)
         4'h0:                alu_result = rs1 + op_b;
         4'h1:                alu_result = rs1 - op_b;
         4'h2, 4'h6, 4'h7:    alu_result = rs1;   // only used when the shift amount is 0
         4'h3:                alu_cmp    = $signed(rs1) < $signed(op_b);
         4'h4:                alu_cmp    = rs1 < op_b;
         4'h5:                alu_result = rs1 ^ op_b;
         4'h8:                alu_result = rs1 | op_b;
         4'h9:                alu_result = rs1 & op_b;
         4'ha:                alu_cmp    = rs1 == op_b;
         4'hb:                alu_cmp    = rs1 != op_b;
         4'hc:                alu_cmp    = $signed(rs1) >= $signed(op_b);
         4'hd:                alu_cmp    = rs1 >= op_b;
         default:             ;
      endcase
      if (alu_control inside {4'h3, 4'h4, 4'ha, 4'hb, 4'hc, 4'hd})
         alu_result = {{(XLEN-1){1'b0}}, alu_cmp};
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start_shift) state_next = SHIFT;
         SHIFT:   if (cnt == SHW'(1)) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // NOTE: sequential blocks use non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_out <= 1'b0;
         result    <= '0;
         cmp       <= 1'b0;
      end else begin
         valid_out <= 1'b0;
         if (accept && !start_shift) begin
            valid_out <= 1'b1;
            result    <= alu_result;
            cmp       <= alu_cmp;
         end else if (last_step) begin
            valid_out <= 1'b1;
            result    <= shreg_step;
            cmp       <= 1'b0;
         end
      end
   end

   // NOTE: the shift datapath has no reset; it is only read in SHIFT, and reset forces IDLE.
   always_ff @(posedge clk) begin
      if (accept) begin
         shreg    <= rs1;
         cnt      <= shamt;
         sh_left  <= (alu_control == 4'h2);
         sh_arith <= (alu_control == 4'h6);
      end else if (state == SHIFT) begin
         shreg <= shreg_step;
         cnt   <= cnt - SHW'(1);
      end
   end

endmodule

// File: tb/tb_serial_shift_alu.sv
// Bench for serial_shift_alu: vector table plus hand sequences for stall,
// back-to-back accept and reset mid-shift; outputs checked through a scoreboard.
module tb_serial_shift_alu;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        valid_in = 1'b0;
   logic [3:0]  alu_control = 4'h0;
   logic        is_shamt = 1'b0;
   logic [31:0] rs1 = '0, rs2 = '0, imm = '0;
   logic        busy, valid_out, cmp;
   logic [31:0] result;

   serial_shift_alu #(.XLEN(32), .SHW(5)) dut (
      .clk(clk), .rst(rst), .valid_in(valid_in), .alu_control(alu_control),
      .is_shamt(is_shamt), .rs1(rs1), .rs2(rs2), .imm(imm),
      .busy(busy), .valid_out(valid_out), .result(result), .cmp(cmp)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   typedef struct {
      string       name;
      logic [31:0] res;
      logic        c;
      int          cyc;
   } exp_t;

   exp_t exp_q[$];

   typedef struct {
      string       name;
      logic [3:0]  code;
      logic        sh;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] im;
      logic [31:0] res;
      logic        c;
      int          lat;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input string name, input logic [3:0] code, input logic sh,
                               input logic [31:0] a, input logic [31:0] b, input logic [31:0] im,
                               input logic [31:0] res, input logic c, input int lat);
      vec_t v;
      v.name = name; v.code = code; v.sh = sh; v.a = a; v.b = b; v.im = im;
      v.res = res; v.c = c; v.lat = lat;
      return v;
   endfunction

   // Scoreboard: every valid_out pulse must match the oldest expectation, including its cycle.
   always @(negedge clk) begin
      if (valid_out) begin
         if (exp_q.size() == 0) begin
            check("unexpected_valid_out", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check({e.name, "_result"}, result, e.res);
            check({e.name, "_cmp"}, {31'b0, cmp}, {31'b0, e.c});
            check({e.name, "_cycle"}, 32'(cyc), 32'(e.cyc));
         end
      end
   end

   task automatic drive(input logic [3:0] code, input logic sh, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] im);
      alu_control = code; is_shamt = sh; rs1 = a; rs2 = b; imm = im; valid_in = 1'b1;
   endtask

   task automatic scramble();
      valid_in = 1'b0;
      alu_control = 4'($urandom); is_shamt = 1'($urandom);
      rs1 = $urandom; rs2 = $urandom; imm = $urandom;
   endtask

   task automatic drain(input string name, output int nbusy);
      int guard = 0;
      nbusy = 0;
      while (exp_q.size() != 0 && guard < 100) begin
         @(negedge clk);
         if (busy) nbusy++;
         guard++;
      end
      check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
      exp_q.delete();
   endtask

   task automatic apply(input vec_t v);
      int t_acc, nbusy;
      @(posedge clk); #1;
      drive(v.code, v.sh, v.a, v.b, v.im);
      t_acc = cyc;
      exp_q.push_back('{v.name, v.res, v.c, t_acc + v.lat});
      @(posedge clk); #1;
      scramble();
      drain(v.name, nbusy);
      check({v.name, "_busy_cycles"}, 32'(nbusy), 32'(v.lat - 1));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int t_acc, nbusy, nvo;

      vecs.push_back(mk("add_wrap",   4'h0, 1'b0, 32'hFFFFFFFF, 32'h1, 32'h0, 32'h0, 1'b0, 1));
      vecs.push_back(mk("sub_neg",    4'h1, 1'b0, 32'd5, 32'd7, 32'h0, 32'hFFFFFFFE, 1'b0, 1));
      vecs.push_back(mk("sltu_lt",    4'h4, 1'b0, 32'd5, 32'd7, 32'h0, 32'h1, 1'b1, 1));
      vecs.push_back(mk("slli_31",    4'h2, 1'b1, 32'h1, 32'h0, 32'h3F, 32'h80000000, 1'b0, 32));
      vecs.push_back(mk("sra_4",      4'h6, 1'b0, 32'h80000000, 32'd4, 32'h0, 32'hF8000000, 1'b0, 5));
      vecs.push_back(mk("srl_4",      4'h7, 1'b0, 32'h80000000, 32'd4, 32'h0, 32'h08000000, 1'b0, 5));
      vecs.push_back(mk("sll_0",      4'h2, 1'b0, 32'h12345678, 32'h20, 32'h0, 32'h12345678, 1'b0, 1));
      vecs.push_back(mk("ge_false",   4'hc, 1'b0, 32'hFFFFFFFE, 32'h1, 32'h0, 32'h0, 1'b0, 1));
      vecs.push_back(mk("geu_true",   4'hd, 1'b0, 32'hFFFFFFFE, 32'h1, 32'h0, 32'h1, 1'b1, 1));
      vecs.push_back(mk("eq_true",    4'ha, 1'b0, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'h0, 32'h1, 1'b1, 1));
      vecs.push_back(mk("ne_false",   4'hb, 1'b0, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'h0, 32'h0, 1'b0, 1));
      vecs.push_back(mk("slt_true",   4'h3, 1'b0, 32'hFFFFFFFE, 32'h1, 32'h0, 32'h1, 1'b1, 1));
      vecs.push_back(mk("xor",        4'h5, 1'b0, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h0, 32'hFF00FF00, 1'b0, 1));
      vecs.push_back(mk("or",         4'h8, 1'b0, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h0, 32'hFFF0FFF0, 1'b0, 1));
      vecs.push_back(mk("and",        4'h9, 1'b0, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h0, 32'h00F000F0, 1'b0, 1));
      vecs.push_back(mk("code_e",     4'he, 1'b0, 32'h1, 32'h1, 32'h0, 32'h0, 1'b0, 1));
      vecs.push_back(mk("code_f",     4'hf, 1'b0, 32'h1, 32'h1, 32'h0, 32'h0, 1'b0, 1));
      vecs.push_back(mk("addi",       4'h0, 1'b1, 32'h10, 32'hFFFF, 32'h20, 32'h30, 1'b0, 1));
      vecs.push_back(mk("srai_1",     4'h6, 1'b1, 32'h70000000, 32'h0, 32'hFFFFFFE1, 32'h38000000, 1'b0, 2));
      vecs.push_back(mk("srl_31",     4'h7, 1'b0, 32'h80000000, 32'h1F, 32'h0, 32'h1, 1'b0, 32));
      vecs.push_back(mk("sra_31",     4'h6, 1'b0, 32'h80000000, 32'h1F, 32'h0, 32'hFFFFFFFF, 1'b0, 32));
      vecs.push_back(mk("ne_true",    4'hb, 1'b0, 32'h1, 32'h2, 32'h0, 32'h1, 1'b1, 1));
      vecs.push_back(mk("eq_false",   4'ha, 1'b0, 32'h1, 32'h2, 32'h0, 32'h0, 1'b0, 1));
      vecs.push_back(mk("ge_minmax",  4'hc, 1'b0, 32'h7FFFFFFF, 32'h80000000, 32'h0, 32'h1, 1'b1, 1));

      // Reset state.
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_busy", {31'b0, busy}, 32'd0);
      check("reset_valid_out", {31'b0, valid_out}, 32'd0);
      check("reset_result", result, 32'd0);
      check("reset_cmp", {31'b0, cmp}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      foreach (vecs[i]) apply(vecs[i]);

      // Stall: an add held during the shift is ignored, then accepted in the valid_out cycle.
      @(posedge clk); #1;
      drive(4'h2, 1'b0, 32'h3, 32'd8, 32'h0);
      t_acc = cyc;
      exp_q.push_back('{"stall_sll", 32'h300, 1'b0, t_acc + 9});
      exp_q.push_back('{"stall_add", 32'd123, 1'b0, t_acc + 10});
      @(posedge clk); #1;
      drive(4'h0, 1'b0, 32'd100, 32'd23, 32'h0);
      repeat (9) @(posedge clk);
      #1;
      scramble();
      drain("stall", nbusy);

      // Reset mid-shift: no completion for the abandoned shift.
      @(posedge clk); #1;
      drive(4'h2, 1'b0, 32'h1, 32'd10, 32'h0);
      @(posedge clk); #1;
      scramble();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("midrst_busy", {31'b0, busy}, 32'd0);
      check("midrst_result", result, 32'd0);
      check("midrst_cmp", {31'b0, cmp}, 32'd0);
      nvo = 0;
      repeat (15) begin
         if (valid_out) nvo++;
         @(negedge clk);
      end
      check("midrst_no_valid_out", 32'(nvo), 32'd0);
      apply(mk("add_after_rst", 4'h0, 1'b0, 32'd40, 32'd2, 32'h0, 32'd42, 1'b0, 1));

      repeat (2) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/serial_shift_alu.md
Name: serial_shift_alu

Overview:
- Execution-stage ALU, directly downstream of the ALU decoder. Consumes its 4-bit ALU control code and shift-immediate flag, plus the register and immediate operands.
- Produces the 32-bit result and the branch-compare flag.
- Non-shift ops complete in 1 cycle. Shifts run serially at 1 bit per cycle, so no barrel shifter is needed.
- Core control stalls on `busy` and captures the result on `valid_out`.

Parameters:
- XLEN, 32, datapath width. Only 32 is supported.
- SHW, 5, shift-amount width; must equal log2(XLEN).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- valid_in  in  1  operation request; accepted when valid_in && !busy.
- alu_control  in  4  op code from the ALU decoder.
- is_shamt  in  1  1: operand B = imm; 0: operand B = rs2.
- rs1  in  XLEN  operand A.
- rs2  in  XLEN  register operand B.
- imm  in  XLEN  immediate operand B.
- busy  out  1  high while a serial shift is in progress.
- valid_out  out  1  1-cycle pulse; result/cmp are valid.
- result  out  XLEN  registered result, held until the next completion.
- cmp  out  1  registered compare outcome, held with result.

Behaviour:
- Reset (rst=1 at an edge): state IDLE, busy=0, valid_out=0, result=0, cmp=0. Reset mid-shift abandons the op; no valid_out is produced for it.
- B = is_shamt ? imm : rs2. Shift amount n = B[4:0]; upper bits are ignored.
- Op codes:
  - 0 add, 1 sub.
  - 2 sll, 6 sra, 7 srl.
  - 3 slt (signed <), 4 sltu (unsigned <).
  - 5 xor, 8 or, 9 and.
  - a eq, b ne, c ge (signed >=), d geu (unsigned >=).
  - e/f: result=0, cmp=0.
- Arithmetic is modulo 2^32; no overflow flag.
- Compare codes 3, 4, a, b, c, d: cmp = condition; result = {31'b0, cmp}. All other codes: cmp=0.
- FSM states: IDLE, SHIFT.
- IDLE, accept at cycle T, non-shift op or shift with n=0: result and cmp registered at the end of T; valid_out=1 in cycle T+1; stay IDLE. Latency is 1.
- IDLE, accept at cycle T, shift with n>0: load shift register with A and counter with n; go to SHIFT.
  - Each SHIFT cycle shifts 1 bit and decrements the counter. sll fills 0; srl fills 0; sra fills A[31].
  - On the edge where the counter goes 1->0: result = shift register, valid_out=1, return to IDLE.
  - valid_out appears in cycle T+n+1. busy=1 during cycles T+1..T+n.
- valid_in while busy is ignored; inputs are not latched. Upstream must hold the request.
- Back-to-back: a new op may be accepted in the same cycle valid_out is high.
- valid_out is low in every cycle not listed above.
- Operand inputs may change freely after the accept cycle; only captured values are used.

Test Plan:
- Reset, then add: rs1=0xFFFFFFFF, rs2=1, code 0 -> valid_out at T+1; result=0x00000000; cmp=0.
- sub then sltu: rs1=5, rs2=7, code 1 -> result 0xFFFFFFFE. Next cycle code 4 -> result 1, cmp 1.
- Shifts:
  - slli: rs1=1, imm=0x3F (n=31), is_shamt=1, code 2 -> busy high T+1..T+31; valid_out at T+32; result 0x80000000.
  - sra: rs1=0x80000000, rs2=4, code 6 -> result 0xF8000000 at T+5.
  - srl: same operands, code 7 -> 0x08000000.
  - Shift by 0 -> latency 1; result = rs1.
- Branch compares: rs1=0xFFFFFFFE, rs2=1:
  - code c -> cmp 0.
  - code d -> cmp 1.
  - code a with rs1=rs2 -> cmp 1.
  - code b with rs1=rs2 -> cmp 0.
- Stall: start sll n=8, hold valid_in with a different add during busy -> add ignored; shift result at T+9. Add accepted in the valid_out cycle; its result follows 1 cycle later.
- Reset mid-shift: assert rst at T+3 of an n=10 shift -> busy=0, result=0, no valid_out. A following add completes normally at latency 1.
